// File: rtl/sha256_compress.sv
// SHA-256 compression core: one schedule word per accepted handshake, 64 rounds, then a chaining update.
// Optional build macro SHA256_BLOCK_CNT_EN adds a per-message completed-block counter output (blk_cnt).
module sha256_compress #(
  parameter logic [255:0] H_INIT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic         msg_first,
  input  logic         last_block,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
`ifdef SHA256_BLOCK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_UPDATE = 2'd2} state_e;

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [0:7][31:0]  h_q, h_d;    // chaining value, H0 first
  logic [0:7][31:0]  wv_q, wv_d;  // working variables a..h
  logic              dv_q, dv_d;
  logic              last_q, last_d;
  logic              accept_s;
  logic [0:7][31:0]  src_s, rnd_s;
  logic [31:0]       t1_s, t2_s;

  assign w_ready      = (state_q != S_UPDATE);
  assign busy         = (t_q != 6'd0) || (state_q == S_UPDATE);
  assign digest       = h_q;
  assign digest_valid = dv_q;
  assign accept_s     = w_valid && w_ready;

  // Round 0 starts from the chaining value directly, so the block needs no separate load cycle.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_s = msg_first ? H_INIT : h_q;
    end else begin
      src_s = wv_q;
    end
    t1_s  = src_s[7] + big_sigma1(src_s[4]) + ((src_s[4] & src_s[5]) ^ (~src_s[4] & src_s[6]))
          + K_ROM[t_q] + w_in;
    t2_s  = big_sigma0(src_s[0]) + ((src_s[0] & src_s[1]) ^ (src_s[0] & src_s[2]) ^ (src_s[1] & src_s[2]));
    rnd_s = {t1_s + t2_s, src_s[0], src_s[1], src_s[2], src_s[3] + t1_s, src_s[4], src_s[5], src_s[6]};
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    h_d     = h_q;
    wv_d    = wv_q;
    dv_d    = dv_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          wv_d    = rnd_s;
          t_d     = 6'd1;
          state_d = S_ROUND;
          last_d  = last_block;
          dv_d    = 1'b0;
          if (msg_first) begin
            h_d = H_INIT;
          end else begin
            h_d = h_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUND: begin
        if (accept_s) begin
          wv_d = rnd_s;
          t_d  = t_q + 6'd1;
          if (t_q == 6'd63) begin
            state_d = S_UPDATE;
          end else begin
            state_d = S_ROUND;
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_UPDATE: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + wv_q[i];
        end
        if (last_q) begin
          dv_d = 1'b1;
        end else begin
          dv_d = dv_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      t_q     <= 6'd0;
      h_q     <= H_INIT;
      wv_q    <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      h_q     <= h_d;
      wv_q    <= wv_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
    end
  end

`ifdef SHA256_BLOCK_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count completed blocks of the current message; a new message restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && accept_s && msg_first) begin
      cnt_d = 32'd0;
    end else if (state_q == S_UPDATE) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blk_cnt = cnt_q;
`endif

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Downstream stage of the SHA-256 message scheduler.
- Consumes one 32-bit schedule word W[t] per accepted handshake and runs the 64-round SHA-256 compression with a per-round K constant ROM.
- Adds the working variables into the chaining value H after round 63.
- Presents the 256-bit digest after the last block of a message.

Parameters:
- H_INIT, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19: initial hash value, H0 in the MSBs. Loading the SHA-224 IV gives SHA-224; the consumer uses digest[255:32].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- w_in  in  32  schedule word W[t]
- w_valid  in  1  w_in valid
- w_ready  out  1  block accepts a word this cycle
- msg_first  in  1  sampled with W[0]: this block starts a new message
- last_block  in  1  sampled with W[0]: this block ends the message
- busy  out  1  a block is in progress (round counter nonzero or UPDATE)
- digest  out  256  current H register, H0 in the MSBs
- digest_valid  out  1  digest holds the final hash of a completed message

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, round counter t=0, H=H_INIT, a..h=0.
  - digest_valid=0, busy=0, w_ready=1 after reset is released.
  - Flags cleared.
  - A reset in the middle of a block abandons the block. Nothing partial is ever flagged valid.
- Accept: a word is consumed when w_valid && w_ready on a rising clk edge.
- States:
  - IDLE: w_ready=1, t=0.
    - On accept, latch msg_first and last_block, clear digest_valid, and execute round 0 in the same cycle.
    - The round-0 input is H_INIT if msg_first=1, else the current H.
    - Go to ROUND, t=1.
  - ROUND: w_ready=1.
    - Each accept executes round t on a..h with w_in and K[t], then t++.
    - The accept at t=63 goes to UPDATE.
    - Cycles without w_valid are stalls: state, t and a..h hold.
  - UPDATE (one cycle, w_ready=0):
    - Update each word mod 2^32: H0<=H0+a ... H7<=H7+h.
    - If the latched last_block=1, set digest_valid=1.
    - Go to IDLE.
- Round function, all mod 2^32:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
- Latency: a block with no stalls takes 64 accept cycles plus 1 UPDATE cycle. digest_valid rises on the clk edge that ends UPDATE, i.e. 65 cycles after the first accept.
- Throughput: one block per 65 cycles at best. Upstream must hold W[0] of the next block through the UPDATE cycle.
- digest_valid stays high until the next accepted round-0 word, then clears on that edge. digest stays stable while digest_valid=1.
- msg_first and last_block are ignored on words t=1..63.
- msg_first=0 on the first block after reset chains from H=H_INIT, which is identical to msg_first=1.
- msg_first=1 with last_block=1 is a valid single-block message.
- w_valid during UPDATE is not consumed. The word stays pending and is accepted in the following IDLE cycle.

Optional Feature:
- Macro SHA256_BLOCK_CNT_EN.
- When defined:
  - Adds output port blk_cnt [31:0], the number of blocks completed since the last accepted msg_first=1 word.
  - blk_cnt resets to 0 on rst.
  - An accepted round-0 word with msg_first=1 sets it to 0. The UPDATE cycle then increments it, so it reads 1 after the first block completes.
  - The count wraps at 2^32.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- "abc" single block, msg_first=1, last_block=1, W[0..63] from the bench golden model, w_valid held high -> digest_valid rises 65 cycles after the first accept; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message, one block with W[0]=80000000 and the rest zero -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 2 with msg_first=0, last_block=1 -> digest_valid stays 0 after block 1; final digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- "abc" with random w_valid gaps, plus w_valid asserted during UPDATE -> same digest; w_ready=0 only in UPDATE; no word lost or duplicated; busy=1 from the first accept until UPDATE ends.
- Reset pulse (rst=0) at t=30, then a full "abc" block -> digest_valid=0 immediately on reset and H=H_INIT; the subsequent digest is correct. With SHA256_BLOCK_CNT_EN, blk_cnt=0 after reset, 1 after "abc" completes, and 2 after the two-block message.
- H_INIT overridden to SHA-224 IV c1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4, input "abc" -> digest[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
